// File: rtl/pcpu_hazard_scoreboard_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
package pcpu_hazard_scoreboard_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        logic       load;
        logic       ctrl;
    } Hazard_entry_t;

    localparam int unsigned FWD_NONE = 0;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pcpu_hazard_scoreboard_match.sv
// Finds the youngest in-flight writer of one source register.
module pcpu_hazard_match
    import pcpu_hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  Hazard_entry_t [DEPTH:1] i_entries,
    input  logic [4:0]              i_rs,
    input  logic                    i_rs_used,
    input  logic                    i_id_valid,
    output logic                    o_match,
    output logic [SELW-1:0]         o_stage,
    output logic                    o_load
);

    logic [DEPTH-1:1] w_hit;
    logic             w_unused;

    // The last stage writes the register file before ID reads it, so it is never searched.
    genvar k;
    for (k = 1; k < DEPTH; k++) begin : g_hit
        assign w_hit[k] = i_id_valid && i_rs_used && (i_rs != 5'd0) &&
                          i_entries[k].valid && i_entries[k].wen &&
                          (i_entries[k].rd == i_rs);
    end

    assign w_unused = ^i_entries;

    // Oldest-to-youngest scan so the lowest matching stage wins.
    always_comb begin
        o_match = 1'b0;
        o_stage = SELW'(FWD_NONE);
        o_load  = 1'b0;
        for (int s = DEPTH - 1; s >= 1; s--) begin
            o_match = w_hit[s] ? 1'b1               : o_match;
            o_stage = w_hit[s] ? SELW'(s)           : o_stage;
            o_load  = w_hit[s] ? i_entries[s].load  : o_load;
        end
    end

endmodule

// File: rtl/pcpu_hazard_scoreboard.sv
// Scoreboard hazard unit: tracks in-flight writers after ID and drives
// stall, bubble and flush controls plus registered EX forward selects.
module pcpu_hazard_scoreboard
    import pcpu_hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH         = 3,
    parameter int NUM_RS        = 2,
    parameter int FORWARD       = 1,
    parameter int ALU_READY     = 2,
    parameter int LOAD_READY    = 3,
    parameter int CTRL_MODE     = 1,
    parameter int RESOLVE_STAGE = 2,
    parameter int SELW          = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NUM_RS*5-1:0]    id_rs_addr,
    input  logic [NUM_RS-1:0]      id_rs_used,
    input  logic [4:0]             id_rd_addr,
    input  logic                   id_reg_write,
    input  logic                   id_is_load,
    input  logic                   id_is_ctrl,
    input  logic                   redirect,
    output logic                   en_if,
    output logic                   en_ifid,
    output logic                   nop_ifid,
    output logic                   nop_idex,
    output logic [NUM_RS*SELW-1:0] fwd_sel,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            flush_cnt
);

    Hazard_entry_t [DEPTH:1]   r_entries;
    Hazard_entry_t [DEPTH:1]   w_next_entries;
    Hazard_entry_t             w_id_entry;
    logic [NUM_RS*SELW-1:0]    r_fwd_sel;
    logic [31:0]               r_stall_cnt;
    logic [31:0]               r_flush_cnt;

    logic [NUM_RS-1:0]         w_match;
    logic [NUM_RS-1:0]         w_load;
    logic [SELW-1:0]           w_stage [NUM_RS];
    logic [NUM_RS-1:0]         w_port_stall;
    logic [NUM_RS*SELW-1:0]    w_fwd_next;
    logic                      w_data_stall;
    logic                      w_flush;
    logic                      w_ctrl_pending;
    logic                      w_freeze;
    logic                      w_bubble;

    genvar p;
    for (p = 0; p < NUM_RS; p++) begin : g_port
        pcpu_hazard_match #(
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_match (
            .i_entries  (r_entries),
            .i_rs       (id_rs_addr[5*p +: 5]),
            .i_rs_used  (id_rs_used[p]),
            .i_id_valid (id_valid),
            .o_match    (w_match[p]),
            .o_stage    (w_stage[p]),
            .o_load     (w_load[p])
        );
    end

    // Per-port stall decision and next forward select (stage index after the edge).
    always_comb begin
        w_port_stall = '0;
        w_fwd_next   = '0;
        for (int q = 0; q < NUM_RS; q++) begin
            if (!w_match[q]) begin
                w_fwd_next[q*SELW +: SELW] = SELW'(FWD_NONE);
            end else if (FORWARD == 0) begin
                w_port_stall[q] = 1'b1;
            end else if ((int'(w_stage[q]) + 1) < (w_load[q] ? LOAD_READY : ALU_READY)) begin
                w_port_stall[q] = 1'b1;
            end else begin
                w_fwd_next[q*SELW +: SELW] = SELW'(int'(w_stage[q]) + 1);
            end
        end
    end

    // Unresolved control instruction still ahead of the resolve stage.
    always_comb begin
        w_ctrl_pending = 1'b0;
        for (int s = 1; s < RESOLVE_STAGE; s++) begin
            w_ctrl_pending = w_ctrl_pending | (r_entries[s].valid & r_entries[s].ctrl);
        end
    end

    assign w_data_stall = |w_port_stall;
    assign w_flush      = (CTRL_MODE == 1) && redirect;
    assign w_freeze     = (CTRL_MODE == 0) && ((id_valid && id_is_ctrl) || w_ctrl_pending);
    assign w_bubble     = w_flush || w_data_stall;

    assign w_id_entry = '{valid: id_valid, rd: id_rd_addr, wen: id_reg_write,
                          load: id_is_load, ctrl: id_is_ctrl};

    // Pipeline enables and bubbles: redirect beats data stall beats fetch freeze.
    always_comb begin
        en_if    = 1'b1;
        en_ifid  = 1'b1;
        nop_ifid = 1'b0;
        nop_idex = 1'b0;
        if (rst) begin
            en_if    = 1'b1;
        end else if (w_flush) begin
            nop_ifid = 1'b1;
            nop_idex = 1'b1;
        end else if (w_data_stall) begin
            en_if    = 1'b0;
            en_ifid  = 1'b0;
            nop_idex = 1'b1;
        end else if (w_freeze) begin
            en_if    = 1'b0;
            nop_ifid = 1'b1;
        end else begin
            en_ifid  = 1'b1;
        end
    end

    // Next scoreboard contents: shift one stage, flush the wrong-path stages on redirect.
    always_comb begin
        w_next_entries    = '0;
        w_next_entries[1] = w_bubble ? Hazard_entry_t'('0) : w_id_entry;
        for (int s = 2; s <= DEPTH; s++) begin
            w_next_entries[s]       = r_entries[s-1];
            w_next_entries[s].valid = r_entries[s-1].valid && !(w_flush && (s < RESOLVE_STAGE));
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entries <= '0;
        end else begin
            r_entries <= w_next_entries;
        end
    end

    // Forward selects follow the instruction into EX; stall/flush bubbles carry none.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_sel   <= '0;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            r_fwd_sel <= w_bubble ? '0 : w_fwd_next;
            if (w_data_stall && !w_flush) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_flush) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign fwd_sel   = r_fwd_sel;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pcpu_hazard_scoreboard.sv
// Directed bench: default config, stall-only config and freeze-fetch config share one stimulus.
module tb_pcpu_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid;
    logic [9:0]  id_rs_addr;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic        id_is_load;
    logic        id_is_ctrl;
    logic        redirect;

    logic        d0_en_if, d0_en_ifid, d0_nop_ifid, d0_nop_idex;
    logic [3:0]  d0_fwd_sel;
    logic [31:0] d0_stall_cnt, d0_flush_cnt;
    logic        d1_en_if, d1_en_ifid, d1_nop_ifid, d1_nop_idex;
    logic [3:0]  d1_fwd_sel;
    logic [31:0] d1_stall_cnt, d1_flush_cnt;
    logic        d2_en_if, d2_en_ifid, d2_nop_ifid, d2_nop_idex;
    logic [3:0]  d2_fwd_sel;
    logic [31:0] d2_stall_cnt, d2_flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcpu_hazard_scoreboard u_d0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_is_ctrl(id_is_ctrl), .redirect(redirect),
        .en_if(d0_en_if), .en_ifid(d0_en_ifid), .nop_ifid(d0_nop_ifid), .nop_idex(d0_nop_idex),
        .fwd_sel(d0_fwd_sel), .stall_cnt(d0_stall_cnt), .flush_cnt(d0_flush_cnt)
    );

    pcpu_hazard_scoreboard #(.FORWARD(0)) u_d1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_is_ctrl(id_is_ctrl), .redirect(redirect),
        .en_if(d1_en_if), .en_ifid(d1_en_ifid), .nop_ifid(d1_nop_ifid), .nop_idex(d1_nop_idex),
        .fwd_sel(d1_fwd_sel), .stall_cnt(d1_stall_cnt), .flush_cnt(d1_flush_cnt)
    );

    pcpu_hazard_scoreboard #(.CTRL_MODE(0)) u_d2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_is_ctrl(id_is_ctrl), .redirect(redirect),
        .en_if(d2_en_if), .en_ifid(d2_en_ifid), .nop_ifid(d2_nop_ifid), .nop_idex(d2_nop_idex),
        .fwd_sel(d2_fwd_sel), .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd, input logic wen,
                         input logic ld, input logic ctl);
        id_valid     = v;
        id_rs_addr   = {rs1, rs0};
        id_rs_used   = used;
        id_rd_addr   = rd;
        id_reg_write = wen;
        id_is_load   = ld;
        id_is_ctrl   = ctl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        redirect = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        total++; if (d0_en_if !== 1'b1) begin bad++; $display("FAIL reset_en_if got=%0h want=1", d0_en_if); end
        total++; if (d0_en_ifid !== 1'b1) begin bad++; $display("FAIL reset_en_ifid got=%0h want=1", d0_en_ifid); end
        total++; if (d0_nop_ifid !== 1'b0 || d0_nop_idex !== 1'b0) begin bad++; $display("FAIL reset_nops got=%0h%0h want=00", d0_nop_ifid, d0_nop_idex); end
        total++; if (d0_fwd_sel !== 4'h0) begin bad++; $display("FAIL reset_fwd_sel got=%0h want=0", d0_fwd_sel); end
        total++; if (d0_stall_cnt !== 32'd0 || d0_flush_cnt !== 32'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", d0_stall_cnt, d0_flush_cnt); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_alu_forward();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (d0_en_if !== 1'b1 || d0_nop_idex !== 1'b0) begin bad++; $display("FAIL alu_no_stall got=%0h%0h want=10", d0_en_if, d0_nop_idex); end
        tick();
        idle();
        total++; if (d0_fwd_sel !== 4'b0010) begin bad++; $display("FAIL alu_fwd_sel got=%0h want=2", d0_fwd_sel); end
        total++; if (d0_stall_cnt !== 32'd0) begin bad++; $display("FAIL alu_stall_cnt got=%0d want=0", d0_stall_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (d0_nop_idex !== 1'b1 || d0_en_if !== 1'b0 || d0_en_ifid !== 1'b0) begin bad++; $display("FAIL lu_stall got=%0h%0h%0h want=100", d0_nop_idex, d0_en_if, d0_en_ifid); end
        tick();
        total++; if (d0_nop_idex !== 1'b0 || d0_en_if !== 1'b1) begin bad++; $display("FAIL lu_one_cycle got=%0h%0h want=01", d0_nop_idex, d0_en_if); end
        total++; if (d0_fwd_sel !== 4'h0) begin bad++; $display("FAIL lu_bubble_fwd got=%0h want=0", d0_fwd_sel); end
        tick();
        idle();
        total++; if (d0_fwd_sel !== 4'b1111) begin bad++; $display("FAIL lu_fwd_sel got=%0h want=f", d0_fwd_sel); end
        total++; if (d0_stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d want=1", d0_stall_cnt); end
    endtask

    task automatic test_stall_only();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (d1_nop_idex !== 1'b1) begin bad++; $display("FAIL so_stall1 got=%0h want=1", d1_nop_idex); end
        tick();
        total++; if (d1_nop_idex !== 1'b1) begin bad++; $display("FAIL so_stall2 got=%0h want=1", d1_nop_idex); end
        tick();
        total++; if (d1_nop_idex !== 1'b0 || d1_en_if !== 1'b1) begin bad++; $display("FAIL so_release got=%0h%0h want=01", d1_nop_idex, d1_en_if); end
        tick();
        idle();
        total++; if (d1_fwd_sel !== 4'h0) begin bad++; $display("FAIL so_fwd_sel got=%0h want=0", d1_fwd_sel); end
        total++; if (d1_stall_cnt !== 32'd2) begin bad++; $display("FAIL so_stall_cnt got=%0d want=2", d1_stall_cnt); end
    endtask

    task automatic test_x0();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (d0_en_if !== 1'b1 || d1_en_if !== 1'b1) begin bad++; $display("FAIL x0_no_stall got=%0h%0h want=11", d0_en_if, d1_en_if); end
        tick();
        idle();
        total++; if (d0_fwd_sel !== 4'h0) begin bad++; $display("FAIL x0_fwd_sel got=%0h want=0", d0_fwd_sel); end
        total++; if (d0_stall_cnt !== 32'd0 || d1_stall_cnt !== 32'd0) begin bad++; $display("FAIL x0_stall_cnt got=%0d/%0d want=0/0", d0_stall_cnt, d1_stall_cnt); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);
        redirect = 1'b1;
        #1;
        total++; if (d0_nop_ifid !== 1'b1 || d0_nop_idex !== 1'b1) begin bad++; $display("FAIL rd_nops got=%0h%0h want=11", d0_nop_ifid, d0_nop_idex); end
        total++; if (d0_en_if !== 1'b1) begin bad++; $display("FAIL rd_en_if got=%0h want=1", d0_en_if); end
        tick();
        redirect = 1'b0;
        drive(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (d0_nop_idex !== 1'b0 || d0_en_if !== 1'b1) begin bad++; $display("FAIL rd_entry1_invalid got=%0h%0h want=01", d0_nop_idex, d0_en_if); end
        total++; if (d0_flush_cnt !== 32'd1) begin bad++; $display("FAIL rd_flush_cnt got=%0d want=1", d0_flush_cnt); end
        total++; if (d0_stall_cnt !== 32'd0) begin bad++; $display("FAIL rd_stall_cnt got=%0d want=0", d0_stall_cnt); end
        tick();
        idle();
        total++; if (d0_fwd_sel !== 4'h0) begin bad++; $display("FAIL rd_fwd_sel got=%0h want=0", d0_fwd_sel); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (d0_nop_idex !== 1'b1) begin bad++; $display("FAIL rms_stall_before got=%0h want=1", d0_nop_idex); end
        rst = 1'b1;
        #1;
        total++; if (d0_en_if !== 1'b1 || d0_en_ifid !== 1'b1) begin bad++; $display("FAIL rms_enables got=%0h%0h want=11", d0_en_if, d0_en_ifid); end
        total++; if (d0_nop_idex !== 1'b0 || d0_nop_ifid !== 1'b0) begin bad++; $display("FAIL rms_nops got=%0h%0h want=00", d0_nop_idex, d0_nop_ifid); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (d0_nop_idex !== 1'b0) begin bad++; $display("FAIL rms_issue got=%0h want=0", d0_nop_idex); end
        tick();
        idle();
        total++; if (d0_fwd_sel !== 4'h0) begin bad++; $display("FAIL rms_fwd_sel got=%0h want=0", d0_fwd_sel); end
        total++; if (d0_stall_cnt !== 32'd0) begin bad++; $display("FAIL rms_stall_cnt got=%0d want=0", d0_stall_cnt); end
    endtask

    task automatic test_ctrl_freeze();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        total++; if (d2_en_if !== 1'b0 || d2_nop_ifid !== 1'b1) begin bad++; $display("FAIL fz_id got=%0h%0h want=01", d2_en_if, d2_nop_ifid); end
        total++; if (d2_en_ifid !== 1'b1 || d2_nop_idex !== 1'b0) begin bad++; $display("FAIL fz_advance got=%0h%0h want=10", d2_en_ifid, d2_nop_idex); end
        total++; if (d0_en_if !== 1'b1 || d0_nop_ifid !== 1'b0) begin bad++; $display("FAIL fz_predict_mode got=%0h%0h want=10", d0_en_if, d0_nop_ifid); end
        tick();
        idle();
        #1;
        total++; if (d2_en_if !== 1'b0 || d2_nop_ifid !== 1'b1) begin bad++; $display("FAIL fz_pending got=%0h%0h want=01", d2_en_if, d2_nop_ifid); end
        tick();
        total++; if (d2_en_if !== 1'b1 || d2_nop_ifid !== 1'b0) begin bad++; $display("FAIL fz_resolved got=%0h%0h want=10", d2_en_if, d2_nop_ifid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (d0_fwd_sel !== 4'b0010) begin bad++; $display("FAIL b2b_first got=%0h want=2", d0_fwd_sel); end
        drive(1'b1, 5'd6, 5'd5, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        total++; if (d0_fwd_sel !== 4'b1110) begin bad++; $display("FAIL b2b_second got=%0h want=e", d0_fwd_sel); end
        total++; if (d0_stall_cnt !== 32'd0) begin bad++; $display("FAIL b2b_stall_cnt got=%0d want=0", d0_stall_cnt); end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_stall_only();
        test_x0();
        test_redirect_stall();
        test_reset_mid_stall();
        test_ctrl_freeze();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
